// File: rtl/nor_logic_unit.sv
// ---------------------------------------------------------------------------
// nor_logic_unit
//   WIDTH-bit bitwise logic unit, two register stages on valid/ready
//   handshakes. Every gate function in the datapath is built from 2-input
//   NOR cells (nor_lu_nor2). One nor_lu_lane is instantiated per bit.
//
//   Optional feature macro: LU_PARITY_EN
//     defined   -> S2 registers out_par = ^result
//     undefined -> no parity logic, out_par tied to 0
//
// Ports
//   clk, rst           clock / asynchronous active-high reset
//   in_valid/in_ready  operand handshake; in_op selects the function
//   in_a, in_b         operands
//   out_valid/out_ready result handshake
//   out_y              result, out_zero = (out_y == 0), out_par = ^out_y
//   op_count           saturating count of consumed results
//   cnt_clr            synchronous clear of op_count
//
// Opcodes: 0 NOT A, 1 NOT B, 2 NOR, 3 OR, 4 AND, 5 NAND, 6 XOR, 7 XNOR
// ---------------------------------------------------------------------------

// Single 2-input NOR cell; the only gate primitive of the datapath.
module nor_lu_nor2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a | b);
endmodule

// One bit lane: all eight functions from NOR cells, then an opcode select.
module nor_lu_lane (
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  output logic       y
);
  logic na, nb, n_ab, or_w, and_w, nand_w, t_a, t_b, xnor_w, xor_w;

  nor_lu_nor2 u_na   (.a(a),      .b(a),      .y(na));
  nor_lu_nor2 u_nb   (.a(b),      .b(b),      .y(nb));
  nor_lu_nor2 u_nab  (.a(a),      .b(b),      .y(n_ab));
  nor_lu_nor2 u_or   (.a(n_ab),   .b(n_ab),   .y(or_w));
  nor_lu_nor2 u_and  (.a(na),     .b(nb),     .y(and_w));
  nor_lu_nor2 u_nand (.a(and_w),  .b(and_w),  .y(nand_w));
  // t_a = ~a & b, t_b = a & ~b; NOR of the two is the equivalence
  // function, so XOR takes one more inverting NOR.
  nor_lu_nor2 u_ta   (.a(a),      .b(n_ab),   .y(t_a));
  nor_lu_nor2 u_tb   (.a(b),      .b(n_ab),   .y(t_b));
  nor_lu_nor2 u_xnor (.a(t_a),    .b(t_b),    .y(xnor_w));
  nor_lu_nor2 u_xor  (.a(xnor_w), .b(xnor_w), .y(xor_w));

  always_comb begin
    y = 1'b0;
    case (op)
      3'd0: y = na;
      3'd1: y = nb;
      3'd2: y = n_ab;
      3'd3: y = or_w;
      3'd4: y = and_w;
      3'd5: y = nand_w;
      3'd6: y = xor_w;
      3'd7: y = xnor_w;
      default: y = 1'b0;
    endcase
  end
endmodule

module nor_logic_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_par,
  output logic [CNT_W-1:0] op_count,
  input  logic             cnt_clr
);
  localparam int STAGES = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  // vld_pipe[1] = S1 occupied, vld_pipe[2] = S2 occupied (out_valid)
  logic [STAGES:1]  vld_pipe;
  req_t             s1_req;
  logic [WIDTH-1:0] res;
  logic             res_zero;
  logic             s2_load, in_xfer, out_xfer;

  // S2 may take S1's beat when it is empty or draining this cycle.
  assign s2_load  = vld_pipe[1] && (!vld_pipe[2] || out_ready);
  // Ready follows S2 draining combinationally, so a full S1 keeps streaming.
  assign in_ready = !vld_pipe[1] || s2_load;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = vld_pipe[2] && out_ready;
  assign out_valid = vld_pipe[2];

  // ---- S1: operand register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe[1] <= 1'b0;
      s1_req      <= '0;
    end else if (in_xfer) begin
      vld_pipe[1] <= 1'b1;
      s1_req      <= '{op: in_op, a: in_a, b: in_b};
    end else if (s2_load) begin
      vld_pipe[1] <= 1'b0;
    end
  end

  // ---- NOR datapath, one lane per bit ----
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    nor_lu_lane u_lane (
      .op (s1_req.op),
      .a  (s1_req.a[i]),
      .b  (s1_req.b[i]),
      .y  (res[i])
    );
  end

  assign res_zero = ~|res;

  // ---- S2: result register; holds while stalled ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe[2] <= 1'b0;
      out_y       <= '0;
      out_zero    <= 1'b1;
    end else if (s2_load) begin
      vld_pipe[2] <= 1'b1;
      out_y       <= res;
      out_zero    <= res_zero;
    end else if (out_xfer) begin
      vld_pipe[2] <= 1'b0;
    end
  end

`ifdef LU_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          par_q <= 1'b0;
    else if (s2_load) par_q <= ^res;
  end

  assign out_par = par_q;
`else
  assign out_par = 1'b0;
`endif

  // ---- consumed-result counter, saturating ----
  // A clear coinciding with a transfer counts that transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      op_count <= '0;
    else if (cnt_clr)
      op_count <= out_xfer ? CNT_ONE : '0;
    else if (out_xfer && op_count != CNT_MAX)
      op_count <= op_count + CNT_ONE;
  end

endmodule

// File: tb/tb_nor_logic_unit.sv
module tb_nor_logic_unit;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_ready2;
  logic [2:0]   in_op;
  logic [W-1:0] in_a, in_b;
  logic         out_valid, out_valid2, out_ready;
  logic [W-1:0] out_y, out_y2;
  logic         out_zero, out_zero2, out_par, out_par2;
  logic [15:0]  op_count;
  logic [1:0]   op_count2;
  logic         cnt_clr;

  always #5 clk = ~clk;

  nor_logic_unit #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_zero(out_zero),
    .out_par(out_par), .op_count(op_count), .cnt_clr(cnt_clr)
  );

  // Small-counter instance on the same stimulus, for saturation.
  nor_logic_unit #(.WIDTH(W), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid2),
    .out_ready(out_ready), .out_y(out_y2), .out_zero(out_zero2),
    .out_par(out_par2), .op_count(op_count2), .cnt_clr(cnt_clr)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } beat_t;

  beat_t        pend[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_y[$];
  int tests = 0, fails = 0;
  int cyc = 0, acc = 0, cons = 0;
  int cnt_ref = 0, cnt2_ref = 0;
  int first_acc = -1, first_cons = -1, last_cons = -1;
  bit clr_req = 0;

  function automatic logic [W-1:0] model(beat_t t);
    case (t.op)
      3'd0: return ~t.a;
      3'd1: return ~t.b;
      3'd2: return ~(t.a | t.b);
      3'd3: return t.a | t.b;
      3'd4: return t.a & t.b;
      3'd5: return ~(t.a & t.b);
      3'd6: return t.a ^ t.b;
      default: return ~(t.a ^ t.b);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge (or shortly after): drive, sample before the
  // rising edge, update the scoreboard, return at the next falling edge.
  task automatic tick(input bit vreq, input bit rdy);
    beat_t        t;
    logic [W-1:0] e;
    logic         p;
    bit           oxf;
    if (vreq && pend.size() > 0) begin
      t = pend[0];
      in_valid = 1'b1; in_op = t.op; in_a = t.a; in_b = t.b;
    end else begin
      in_valid = 1'b0;
    end
    out_ready = rdy;
    cnt_clr   = clr_req;
    #2;
    if (in_valid && in_ready) begin
      exp_q.push_back(model(pend.pop_front()));
      if (first_acc < 0) first_acc = cyc;
      acc++;
    end
    oxf = out_valid && out_ready;
    if (oxf) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
`ifdef LU_PARITY_EN
        p = ^e;
`else
        p = 1'b0;
`endif
        chk("out_y",    out_y,    e);
        chk("out_zero", out_zero, (e == '0));
        chk("out_par",  out_par,  p);
        chk("out_y2",   out_y2,   e);
        got_y.push_back(out_y);
        if (first_cons < 0) first_cons = cyc;
        last_cons = cyc;
        cons++;
      end
    end
    if (clr_req) begin
      cnt_ref  = oxf ? 1 : 0;
      cnt2_ref = oxf ? 1 : 0;
    end else if (oxf) begin
      cnt_ref++;
      if (cnt2_ref < 3) cnt2_ref++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input string tag, input int target, input int budget, input bit rnd);
    int k = 0;
    while (cons < target && k < budget) begin
      if (rnd) tick(1'($urandom % 2), 1'($urandom % 2));
      else     tick(1'b1, 1'b1);
      k++;
    end
    chk(tag, cons, target);
  endtask

  initial begin
    int c0, a0, k;
    logic [W-1:0] seq_exp [8];
    beat_t b;
    seq_exp = '{8'h5A, 8'hF0, 8'h50, 8'hAF, 8'h05, 8'hFA, 8'hAA, 8'h55};

    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    out_ready = 1'b0; cnt_clr = 1'b0;
    @(negedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y",     out_y,     0);
    chk("rst_out_zero",  out_zero,  1);
    chk("rst_out_par",   out_par,   0);
    chk("rst_op_count",  op_count,  0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // ---- ops 0..7 on A5/0F, back to back ----
    for (int i = 0; i < 8; i++) pend.push_back('{3'(i), 8'hA5, 8'h0F});
    got_y.delete(); first_acc = -1; first_cons = -1;
    drain("seq_drain", cons + 8, 60, 1'b0);
    chk("seq_latency", first_cons - first_acc, 2);
    chk("seq_no_bubble", last_cons - first_cons, 7);
    for (int i = 0; i < 8; i++) chk($sformatf("seq_y%0d", i), got_y[i], seq_exp[i]);
    chk("seq_op_count", op_count, 8);
    chk("sat_after_8", op_count2, 3);

    // ---- zero flag and parity corner beats ----
    pend.push_back('{3'd4, 8'hF0, 8'h0F});
    drain("and_drain", cons + 1, 20, 1'b0);
    chk("and_zero_y", got_y[$], 8'h00);
    pend.push_back('{3'd3, 8'h01, 8'h02});
    drain("or_drain", cons + 1, 20, 1'b0);
    chk("or_y", got_y[$], 8'h03);

    // ---- backpressure: 4 beats, consumer stalled 5 cycles ----
    c0 = cons; a0 = acc;
    pend.push_back('{3'd6, 8'h3C, 8'h0F});
    pend.push_back('{3'd0, 8'h00, 8'hFF});
    pend.push_back('{3'd2, 8'h12, 8'h34});
    pend.push_back('{3'd7, 8'hFF, 8'h00});
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0);
      if (i == 2) begin
        chk("bp_ready_drop", in_ready, 0);
        chk("bp_hold_y_early", out_y, 8'h33);
      end
    end
    chk("bp_accepts", acc - a0, 2);
    chk("bp_hold_y", out_y, 8'h33);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_ready2", in_ready2, 0);
    out_ready = 1'b1;
    #1 chk("bp_ready_back", in_ready, 1);
    drain("bp_drain", c0 + 4, 40, 1'b0);
    chk("bp_y_last", got_y[$], 8'h00);
    chk("bp_y_first", got_y[$-3], 8'h33);

    // ---- counter clear / saturation on CNT_W=2 ----
    clr_req = 1; tick(1'b0, 1'b0); clr_req = 0;
    chk("clr_only", op_count, 0);
    chk("clr_only2", op_count2, 0);
    for (int i = 0; i < 5; i++) pend.push_back('{3'($urandom), 8'($urandom), 8'($urandom)});
    drain("sat_drain", cons + 5, 40, 1'b0);
    chk("cnt5", op_count, 5);
    chk("sat3", op_count2, 3);
    pend.push_back('{3'd5, 8'h0F, 8'h3C});
    k = 0;
    while (!out_valid && k < 10) begin tick(1'b1, 1'b0); k++; end
    chk("clr_wait", out_valid, 1);
    clr_req = 1; tick(1'b0, 1'b1); clr_req = 0;
    chk("clr_xfer", op_count, 1);
    chk("clr_xfer2", op_count2, 1);

    // ---- random handshakes, 1000 beats ----
    clr_req = 1; tick(1'b0, 1'b0); clr_req = 0;
    for (int i = 0; i < 1000; i++) begin
      b.op = 3'($urandom); b.a = 8'($urandom); b.b = 8'($urandom);
      pend.push_back(b);
    end
    drain("rand_drain", cons + 1000, 20000, 1'b1);
    chk("rand_op_count", op_count, 1000);
    chk("rand_cnt_model", op_count, cnt_ref);
    chk("rand_cnt2_model", op_count2, cnt2_ref);
    chk("rand_exp_empty", exp_q.size(), 0);

    // ---- reset with both stages full ----
    for (int i = 0; i < 3; i++) pend.push_back('{3'd3, 8'h11, 8'h22});
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    chk("full_out_valid", out_valid, 1);
    chk("full_in_ready", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_y", out_y, 0);
    chk("mid_rst_op_count", op_count, 0);
    chk("mid_rst_out_zero", out_zero, 1);
    chk("mid_rst_out_valid2", out_valid2, 0);
    chk("mid_rst_op_count2", op_count2, 0);
    pend.delete(); exp_q.delete(); cnt_ref = 0; cnt2_ref = 0;
    @(negedge clk);
    rst = 1'b0;
    pend.push_back('{3'd1, 8'h00, 8'hC3});
    first_acc = -1; first_cons = -1;
    drain("post_rst_drain", cons + 1, 20, 1'b0);
    chk("post_rst_latency", first_cons - first_acc, 2);
    chk("post_rst_y", got_y[$], 8'h3C);
    chk("post_rst_count", op_count, 1);
    chk("post_rst_zero2", out_zero2 | out_par2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
